// File: rtl/fp_wb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fp_wb_arbiter_pkg
//   Shared FP writeback types for the FPU result arbiter.
//
//   Contents:
//     FP_FLEN, FP_ID_W, FP_NUM_UNITS - default data, id and unit-count sizes
//     FFLAGS_W                       - exception-flag width (NV,DZ,OF,UF,NX)
//     FFLAG_*                        - bit positions inside an fflags vector
//     fp_wb_req_t                    - one producer's writeback request
//     fp_wb_out_t                    - the held writeback result
//     nan_box_single()               - NaN-boxes a 32-bit value into FP_FLEN
//
//   The struct fields are sized by the package constants.  Modules that use
//   them take those constants as their parameter defaults.
// ---------------------------------------------------------------------------
package fp_wb_arbiter_pkg;

    localparam int FP_FLEN      = 64;
    localparam int FP_ID_W      = 3;
    localparam int FP_NUM_UNITS = 4;
    localparam int FFLAGS_W     = 5;

    // Bit positions inside an fflags vector, matching fcsr.fflags ordering.
    localparam int FFLAG_NX = 0;
    localparam int FFLAG_UF = 1;
    localparam int FFLAG_OF = 2;
    localparam int FFLAG_DZ = 3;
    localparam int FFLAG_NV = 4;

    typedef struct packed {
        logic [FP_ID_W-1:0]  id;
        logic [FP_FLEN-1:0]  rd;
        logic [FFLAGS_W-1:0] fflags;
        logic                single;
    } fp_wb_req_t;

    typedef struct packed {
        logic [FP_ID_W-1:0]  id;
        logic [FP_FLEN-1:0]  data;
        logic [FFLAGS_W-1:0] fflags;
    } fp_wb_out_t;

    // A single-precision value in a wider FP register has every upper bit
    // set, so a double-precision read of it is a quiet NaN.
    function automatic logic [FP_FLEN-1:0] nan_box_single(input logic [31:0] value);
        return {{(FP_FLEN-32){1'b1}}, value};
    endfunction

endpackage

// File: rtl/fp_wb_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin pick.  The scan starts at index ptr and
//   moves upward, wrapping from N-1 to 0.  The first asserted request wins.
//   The caller owns the pointer register, which lets the integer writeback
//   path reuse this block with its own update policy.
//
//   Parameters:
//     N      - number of requesters (>= 2)
//     IDX_W  - width of an index into the requesters
//   Ports:
//     req    in  [N-1:0]      request vector
//     ptr    in  [IDX_W-1:0]  highest-priority index this cycle
//     grant  out [N-1:0]      one-hot grant; zero when nothing requests
//     winner out [IDX_W-1:0]  index of the granted requester
//     valid  out              some requester was granted
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] winner,
    output logic             valid
);

    // (base + off) mod N.  One guard bit keeps the sum from overflowing
    // before the single conditional subtraction.
    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                  input int               off);
        logic [IDX_W:0] sum;
        sum = {1'b0, base} + (IDX_W+1)'(off);
        if (sum >= (IDX_W+1)'(N)) begin
            sum = sum - (IDX_W+1)'(N);
        end
        return sum[IDX_W-1:0];
    endfunction

    always_comb begin
        grant  = '0;
        winner = '0;
        valid  = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!valid && req[wrap_idx(ptr, k)]) begin
                grant[wrap_idx(ptr, k)] = 1'b1;
                winner                  = wrap_idx(ptr, k);
                valid                   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_wb_arbiter.sv
// ---------------------------------------------------------------------------
// fp_wb_arbiter
//   Responder end of the FPU writeback handshake.  NUM_UNITS result
//   producers raise req_done.  Each cycle the output slot can take a result,
//   one producer is acked in round-robin order.  Its result is registered and
//   presented to the FP register-file commit port under wb_valid/wb_ready.
//   A sticky fflags accumulator collects the flags of every retired result
//   for fcsr.
//
//   Parameters: NUM_UNITS (>=2), FLEN, ID_W, FFLAGS_W.
//   Ports:
//     clk         in   clock
//     rst         in   asynchronous reset, active low
//     req_done    in   [NUM_UNITS]           unit i holds a result
//     req_ack     out  [NUM_UNITS]           one-hot; unit i accepted this cycle
//     req_id      in   [NUM_UNITS*ID_W]      per-unit instruction id
//     req_rd      in   [NUM_UNITS*FLEN]      per-unit result
//     req_fflags  in   [NUM_UNITS*FFLAGS_W]  per-unit exception flags
//     req_single  in   [NUM_UNITS]           result is single precision
//     wb_valid    out  output register holds a result
//     wb_ready    in   downstream takes the result
//     wb_id       out  [ID_W]      id of the held result
//     wb_data     out  [FLEN]      held result
//     wb_fflags   out  [FFLAGS_W]  flags of the held result
//     fflags_acc  out  [FFLAGS_W]  sticky OR of retired flags
//     fflags_clr  in   clear the accumulator
//
//   Build option:
//     FP_WB_NAN_BOX_EN - when defined, a single-precision winner is captured
//                        NaN-boxed (upper FLEN-32 bits all ones).  When it is
//                        undefined, req_single is ignored.
// ---------------------------------------------------------------------------
module fp_wb_arbiter #(
    parameter int NUM_UNITS = fp_wb_arbiter_pkg::FP_NUM_UNITS,
    parameter int FLEN      = fp_wb_arbiter_pkg::FP_FLEN,
    parameter int ID_W      = fp_wb_arbiter_pkg::FP_ID_W,
    parameter int FFLAGS_W  = fp_wb_arbiter_pkg::FFLAGS_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_UNITS-1:0]          req_done,
    output logic [NUM_UNITS-1:0]          req_ack,
    input  logic [NUM_UNITS*ID_W-1:0]     req_id,
    input  logic [NUM_UNITS*FLEN-1:0]     req_rd,
    input  logic [NUM_UNITS*FFLAGS_W-1:0] req_fflags,
    input  logic [NUM_UNITS-1:0]          req_single,
    output logic                          wb_valid,
    input  logic                          wb_ready,
    output logic [ID_W-1:0]               wb_id,
    output logic [FLEN-1:0]               wb_data,
    output logic [FFLAGS_W-1:0]           wb_fflags,
    output logic [FFLAGS_W-1:0]           fflags_acc,
    input  logic                          fflags_clr
);

    import fp_wb_arbiter_pkg::*;

    localparam int IDX_W = $clog2(NUM_UNITS);

    logic [IDX_W-1:0]     rr_ptr;
    logic                 slot_free;
    logic [NUM_UNITS-1:0] arb_req;
    logic [NUM_UNITS-1:0] grant_p0;
    logic [IDX_W-1:0]     winner_p0;
    logic                 vld_p0;
    logic                 retire;
    fp_wb_req_t           win_req_p0;
    fp_wb_out_t           out_nxt_p0;
    fp_wb_out_t           out_p1;
    logic                 vld_p1;

    // ---- p0: grant (combinational) ---------------------------------------
    // The slot can take a new result when it is empty or drains this cycle.
    // While it is stalled, no producer is acked, so every producer keeps
    // its result.
    assign slot_free = ~vld_p1 | wb_ready;
    assign arb_req   = req_done & {NUM_UNITS{slot_free}};

    rr_arbiter #(
        .N     (NUM_UNITS),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req    (arb_req),
        .ptr    (rr_ptr),
        .grant  (grant_p0),
        .winner (winner_p0),
        .valid  (vld_p0)
    );

    // The ack is combinational and the reset is asynchronous.  Gate the ack
    // with reset so that no producer drops its result during reset.
    assign req_ack = grant_p0 & {NUM_UNITS{rst}};

    always_comb begin
        win_req_p0.id     = req_id[winner_p0*ID_W +: ID_W];
        win_req_p0.rd     = req_rd[winner_p0*FLEN +: FLEN];
        win_req_p0.fflags = req_fflags[winner_p0*FFLAGS_W +: FFLAGS_W];
        win_req_p0.single = req_single[winner_p0];
    end

`ifdef FP_WB_NAN_BOX_EN
    always_comb begin
        out_nxt_p0.id     = win_req_p0.id;
        out_nxt_p0.fflags = win_req_p0.fflags;
        out_nxt_p0.data   = win_req_p0.single ? nan_box_single(win_req_p0.rd[31:0])
                                              : win_req_p0.rd;
    end
`else
    logic unused_single;
    assign unused_single = win_req_p0.single;

    always_comb begin
        out_nxt_p0.id     = win_req_p0.id;
        out_nxt_p0.fflags = win_req_p0.fflags;
        out_nxt_p0.data   = win_req_p0.rd;
    end
`endif

    // ---- p1: output register and round-robin pointer ---------------------
    // A grant in the same cycle as a drain replaces the held result, so the
    // slot stays full on back-to-back cycles.  The pointer moves only on a
    // grant.  Idle and stalled cycles leave it where it is.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1 <= 1'b0;
            out_p1 <= '0;
            rr_ptr <= '0;
        end else begin
            if (vld_p0) begin
                vld_p1 <= 1'b1;
                out_p1 <= out_nxt_p0;
                rr_ptr <= (winner_p0 == IDX_W'(NUM_UNITS-1)) ? '0 : winner_p0 + 1'b1;
            end else if (wb_ready) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    // ---- retirement: sticky flag accumulator -----------------------------
    // A clear in the same cycle as a retirement keeps the retiring flags.
    // Those flags belong to an instruction that completes after the clear.
    assign retire = vld_p1 & wb_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fflags_acc <= '0;
        end else if (fflags_clr) begin
            fflags_acc <= retire ? out_p1.fflags : '0;
        end else if (retire) begin
            fflags_acc <= fflags_acc | out_p1.fflags;
        end
    end

    assign wb_valid  = vld_p1;
    assign wb_id     = out_p1.id;
    assign wb_data   = out_p1.data;
    assign wb_fflags = out_p1.fflags;

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fp_wb_arbiter
//   Directed testbench for fp_wb_arbiter (NUM_UNITS=4, FLEN=64, ID_W=3).
//   Inputs change 1 ns after a rising edge.  Acks are sampled 1 ns after
//   that.  Registered outputs are sampled 1 ns after the rising edge.
//   Define FP_WB_NAN_BOX_EN for both the bench and the design to check the
//   NaN-boxing build.
// ---------------------------------------------------------------------------
module tb_fp_wb_arbiter;

    localparam int NU = 4;
    localparam int FL = 64;
    localparam int IW = 3;
    localparam int FW = 5;

    logic             clk;
    logic             rst;
    logic [NU-1:0]    req_done;
    logic [NU-1:0]    req_ack;
    logic [NU*IW-1:0] req_id;
    logic [NU*FL-1:0] req_rd;
    logic [NU*FW-1:0] req_fflags;
    logic [NU-1:0]    req_single;
    logic             wb_valid;
    logic             wb_ready;
    logic [IW-1:0]    wb_id;
    logic [FL-1:0]    wb_data;
    logic [FW-1:0]    wb_fflags;
    logic [FW-1:0]    fflags_acc;
    logic             fflags_clr;

    int n_chk;
    int n_err;

    fp_wb_arbiter #(
        .NUM_UNITS (NU),
        .FLEN      (FL),
        .ID_W      (IW),
        .FFLAGS_W  (FW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_done   (req_done),
        .req_ack    (req_ack),
        .req_id     (req_id),
        .req_rd     (req_rd),
        .req_fflags (req_fflags),
        .req_single (req_single),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_id      (wb_id),
        .wb_data    (wb_data),
        .wb_fflags  (wb_fflags),
        .fflags_acc (fflags_acc),
        .fflags_clr (fflags_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_unit(input int u, input logic d, input logic [IW-1:0] id,
                            input logic [FL-1:0] rd, input logic [FW-1:0] ff,
                            input logic sgl);
        req_done[u]            = d;
        req_id[u*IW +: IW]     = id;
        req_rd[u*FL +: FL]     = rd;
        req_fflags[u*FW +: FW] = ff;
        req_single[u]          = sgl;
    endtask

    logic [63:0] nan_exp;

    initial begin
        n_chk      = 0;
        n_err      = 0;
        rst        = 1'b1;
        req_done   = '0;
        req_id     = '0;
        req_rd     = '0;
        req_fflags = '0;
        req_single = '0;
        wb_ready   = 1'b0;
        fflags_clr = 1'b0;

        // Reset: all outputs are zero, and a pending request gets no ack.
        #2 rst = 1'b0;
        req_done = 4'b0001;
        #1;
        chk("rst_ack",    64'(req_ack),    64'h0);
        chk("rst_valid",  64'(wb_valid),   64'h0);
        chk("rst_id",     64'(wb_id),      64'h0);
        chk("rst_data",   wb_data,         64'h0);
        chk("rst_fflags", 64'(wb_fflags),  64'h0);
        chk("rst_acc",    64'(fflags_acc), 64'h0);
        tick();
        tick();
        req_done = '0;
        rst      = 1'b1;

        // Single request from unit 2.  The ack comes the same cycle, and the
        // result is registered one cycle later.
        set_unit(2, 1'b1, 3'd5, 64'h4000_0000_0000_0000, 5'b00001, 1'b0);
        #1 chk("single_ack", 64'(req_ack), 64'h4);
        tick();
        req_done[2] = 1'b0;
        #1;
        chk("single_valid",  64'(wb_valid),  64'h1);
        chk("single_id",     64'(wb_id),     64'h5);
        chk("single_data",   wb_data,        64'h4000_0000_0000_0000);
        chk("single_fflags", 64'(wb_fflags), 64'h1);
        chk("single_noack",  64'(req_ack),   64'h0);
        wb_ready = 1'b1;
        tick();
        chk("single_drain", 64'(wb_valid),   64'h0);
        chk("single_acc",   64'(fflags_acc), 64'h1);

        // Wrap-around: the pointer is 3, and units 0 and 3 request.
        set_unit(0, 1'b1, 3'd1, 64'h1000, 5'b0, 1'b0);
        set_unit(3, 1'b1, 3'd4, 64'h1003, 5'b0, 1'b0);
        #1 chk("wrap_ack3", 64'(req_ack), 64'h8);
        tick();
        req_done[3] = 1'b0;
        #1;
        chk("wrap_id3",  64'(wb_id),   64'h4);
        chk("wrap_ack0", 64'(req_ack), 64'h1);
        tick();
        req_done[0] = 1'b0;
        chk("wrap_id0", 64'(wb_id), 64'h1);

        // Grant unit 3 alone so that the pointer returns to 0.
        req_done[3] = 1'b1;
        tick();
        req_done[3] = 1'b0;
        chk("ptr0_id", 64'(wb_id), 64'h4);

        // All four units request continuously with ready held high.  The
        // grants go 0,1,2,3,0 and the slot holds a new result every cycle.
        for (int u = 0; u < NU; u++) set_unit(u, 1'b1, IW'(u + 1), 64'h1000 + 64'(u), 5'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            #1 chk($sformatf("rr_ack%0d", k), 64'(req_ack), 64'(1 << (k % 4)));
            tick();
            chk($sformatf("rr_id%0d", k),    64'(wb_id),    64'((k % 4) + 1));
            chk($sformatf("rr_valid%0d", k), 64'(wb_valid), 64'h1);
        end

        // Backpressure: unit 0's result is held, the pointer is 1, and unit 1
        // requests.
        req_done = 4'b0010;
        wb_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1 chk($sformatf("bp_noack%0d", k), 64'(req_ack), 64'h0);
            tick();
            chk($sformatf("bp_id%0d", k),   64'(wb_id),   64'h1);
            chk($sformatf("bp_data%0d", k), wb_data,      64'h1000);
        end
        wb_ready = 1'b1;
        #1 chk("bp_ack1", 64'(req_ack), 64'h2);
        tick();
        req_done = '0;
        chk("bp_id_new",   64'(wb_id), 64'h2);
        chk("bp_data_new", wb_data,    64'h1001);

        // Flags.  First, a clear while unit 1's result (flags 0) retires.
        // Unit 0 then presents 10000, followed by 00100.
        fflags_clr = 1'b1;
        set_unit(0, 1'b1, 3'd6, 64'h2000, 5'b10000, 1'b0);
        tick();
        fflags_clr = 1'b0;
        chk("ff_clr_ret0", 64'(fflags_acc), 64'h0);
        set_unit(0, 1'b1, 3'd7, 64'h2001, 5'b00100, 1'b0);
        #1 chk("ff_ack0", 64'(req_ack), 64'h1);
        tick();
        req_done = '0;
        chk("ff_acc_a", 64'(fflags_acc), 64'h10);
        tick();
        chk("ff_acc_b",   64'(fflags_acc), 64'h14);
        chk("ff_drained", 64'(wb_valid),   64'h0);
        set_unit(2, 1'b1, 3'd3, 64'h2002, 5'b00010, 1'b0);
        tick();
        req_done   = '0;
        fflags_clr = 1'b1;
        tick();
        chk("ff_clr_with_ret", 64'(fflags_acc), 64'h02);
        tick();
        fflags_clr = 1'b0;
        chk("ff_clr_alone", 64'(fflags_acc), 64'h0);

        // Single-precision result from unit 1.
        set_unit(1, 1'b1, 3'd2, 64'h0000_0000_3F80_0000, 5'b0, 1'b1);
        tick();
        req_done      = '0;
        req_single[1] = 1'b0;
`ifdef FP_WB_NAN_BOX_EN
        nan_exp = 64'hFFFF_FFFF_3F80_0000;
`else
        nan_exp = 64'h0000_0000_3F80_0000;
`endif
        chk("nanbox_data", wb_data, nan_exp);

        // Reset during a transfer discards the held result.  After release,
        // the pointer is back at 0, so unit 3 is the only candidate and wins.
        wb_ready = 1'b0;
        set_unit(3, 1'b1, 3'd4, 64'h3003, 5'b0, 1'b0);
        #1 rst = 1'b0;
        #1;
        chk("midrst_valid", 64'(wb_valid), 64'h0);
        chk("midrst_data",  wb_data,       64'h0);
        chk("midrst_ack",   64'(req_ack),  64'h0);
        rst = 1'b1;
        #1 chk("postrst_ack", 64'(req_ack), 64'h8);
        tick();
        req_done = '0;
        chk("postrst_id",   64'(wb_id),   64'h4);
        chk("postrst_data", wb_data,      64'h3003);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
